// File: rtl/iter_alu.sv
// Registered execute-stage ALU: single-cycle arithmetic/logic ops plus iterative
// MUL (shift-add) and MOD (restoring division remainder), each taking N cycles.
module iter_alu #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [3:0]   opcode_i,
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [N-1:0] result_o,
    output logic [3:0]   ALUFlags,
    output logic         div_zero_o
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned SW = $clog2(N);

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpXor = 4'b0100;
    localparam logic [3:0] OpShl = 4'b0101;
    localparam logic [3:0] OpShr = 4'b0110;
    localparam logic [3:0] OpMul = 4'b0111;
    localparam logic [3:0] OpMod = 4'b1000;

    typedef enum logic [1:0] {StIdle, StMulRun, StModRun} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    // MUL: multiplier shifting right; MOD: dividend shifting left.
    logic [N-1:0]   opa_q, opa_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    // MUL: partial product; MOD: remainder in the low N bits.
    logic [2*N-1:0] acc_q, acc_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           dz_q, dz_d;
    logic           valid_q, valid_d;

    function automatic logic [3:0] pack_flags(input logic [N-1:0] r, input logic c,
                                              input logic v);
        return {v, c, r[N-1], (r == '0)};
    endfunction

    // Single-cycle datapath
    logic [N:0]    add_w, sub_w;
    logic [SW-1:0] sh_amt;
    logic [N-1:0]  alu_res;
    logic          alu_c, alu_v;

    always_comb begin
        add_w   = {1'b0, a_i} + {1'b0, b_i};
        sub_w   = {1'b0, a_i} - {1'b0, b_i};
        sh_amt  = b_i[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (opcode_i)
            OpAdd: begin
                alu_res = add_w[N-1:0];
                alu_c   = add_w[N];
                alu_v   = (a_i[N-1] == b_i[N-1]) && (add_w[N-1] != a_i[N-1]);
            end
            OpSub: begin
                alu_res = sub_w[N-1:0];
                alu_c   = ~sub_w[N];
                alu_v   = (a_i[N-1] != b_i[N-1]) && (sub_w[N-1] != a_i[N-1]);
            end
            OpAnd:   alu_res = a_i & b_i;
            OpOr:    alu_res = a_i | b_i;
            OpXor:   alu_res = a_i ^ b_i;
            OpShl:   alu_res = a_i << sh_amt;
            OpShr:   alu_res = a_i >> sh_amt;
            default: alu_res = '0;
        endcase
    end

    // Iterative datapath
    logic [2*N-1:0] mul_acc_next;
    logic [N:0]     rem_shift, rem_sub;
    logic [N-1:0]   rem_next;
    logic           last_iter;

    always_comb begin
        mul_acc_next = acc_q + (opa_q[0] ? mcand_q : '0);
        rem_shift    = {acc_q[N-1:0], opa_q[N-1]};
        rem_sub      = rem_shift - {1'b0, opb_q};
        // With b=0 both arms equal rem_shift[N-1:0], so the remainder ends up as a.
        rem_next     = rem_sub[N] ? rem_shift[N-1:0] : rem_sub[N-1:0];
        last_iter    = (cnt_q == CW'(N - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        flags_d  = flags_q;
        dz_d     = dz_q;
        valid_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (opcode_i == OpMul || opcode_i == OpMod) begin
                        opb_d = b_i;
                        acc_d = '0;
                        cnt_d = '0;
                        if (opcode_i == OpMul) begin
                            opa_d   = b_i;
                            mcand_d = {{N{1'b0}}, a_i};
                            state_d = StMulRun;
                        end else begin
                            opa_d   = a_i;
                            state_d = StModRun;
                        end
                    end else begin
                        result_d = alu_res;
                        flags_d  = pack_flags(alu_res, alu_c, alu_v);
                        dz_d     = 1'b0;
                        valid_d  = 1'b1;
                    end
                end
            end
            StMulRun: begin
                acc_d   = mul_acc_next;
                mcand_d = mcand_q << 1;
                opa_d   = opa_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    result_d = mul_acc_next[N-1:0];
                    flags_d  = pack_flags(mul_acc_next[N-1:0], |mul_acc_next[2*N-1:N], 1'b0);
                    dz_d     = 1'b0;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            StModRun: begin
                acc_d = {{N{1'b0}}, rem_next};
                opa_d = opa_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    result_d = rem_next;
                    flags_d  = pack_flags(rem_next, 1'b0, 1'b0);
                    dz_d     = (opb_q == '0);
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            dz_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            dz_q     <= dz_d;
            valid_q  <= valid_d;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign valid_o    = valid_q;
    assign result_o   = result_q;
    assign ALUFlags   = flags_q;
    assign div_zero_o = dz_q;

endmodule
